stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter W_IN, default 8, narrow lane width in bits.
REQ-002 SHALL have parameter RATIO, default 4, narrow words per wide word; legal range >= 2.
REQ-003 SHALL derive localparams W_OUT = W_IN*RATIO and W_CNT = $clog2(RATIO+1); neither is overridable.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port fifo_rdata, input, W_IN, head entry of the upstream synchronous FIFO, valid combinationally whenever fifo_empty is low.
REQ-007 SHALL have port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-008 SHALL have port fifo_ren, output, 1, pop strobe to the upstream FIFO.
REQ-009 SHALL have port flush_partial, input, 1, level request to emit an incomplete wide word.
REQ-010 SHALL have port out_data, output, W_OUT, packed wide word; lane 0 in bits [W_IN-1:0].
REQ-011 SHALL have port out_count, output, W_CNT, number of valid lanes in out_data (1..RATIO).
REQ-012 SHALL have port out_valid, output, 1, out_data and out_count are valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the word when high with out_valid.

Function
REQ-014 SHALL hold an accumulator of RATIO-1 lanes and a lane counter cnt (0..RATIO-1); first popped word goes to lane 0.
REQ-015 SHALL define out_free = !out_valid || out_ready.
REQ-016 SHALL drive fifo_ren = !fifo_empty && !flush_pend && (cnt < RATIO-1 || out_free), purely combinationally; never pop when fifo_empty.
REQ-017 SHALL, on a pop with cnt < RATIO-1, write fifo_rdata into lane cnt and increment cnt.
REQ-018 SHALL, on a pop with cnt == RATIO-1, load out_data = {fifo_rdata, accumulator}, out_count = RATIO, set out_valid and clear cnt, all in the same edge (1-cycle latency from final pop to out_valid).
REQ-019 SHALL sustain one pop per cycle and one wide word per RATIO cycles when the FIFO is non-empty and out_ready is high.
REQ-020 SHALL hold out_data/out_count stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on an edge where out_valid && out_ready and no new word loads; load and drain in the same cycle SHALL leave out_valid high with the new word.
REQ-022 SHALL define flush_pend = flush_partial && cnt != 0; flush_partial with cnt == 0 SHALL have no effect and SHALL NOT block pops.
REQ-023 SHALL, when flush_pend && out_free, load out_data = accumulator with unused upper lanes zero, out_count = cnt, set out_valid, clear cnt.
REQ-024 SHALL, when flush_pend && !out_free, wait with no pop until out_free, then act per REQ-023.
REQ-025 SHALL give flush_partial priority over popping in the same cycle; the FIFO head stays for the next word.
REQ-026 SHALL leave stale lanes undefined-free: unused lanes of the output are zero on partial words; accumulator lanes need not clear after transfer.

Reset
REQ-027 SHALL, on a clock edge with rst_n low, set out_valid 0, out_data 0, out_count 0, cnt 0, accumulator 0, regardless of any other input.
REQ-028 SHALL drive fifo_ren low during any cycle rst_n is low; a partially accumulated word is discarded.

Structure
REQ-029 SHALL need no shared package; W_OUT and W_CNT are local to the module.
REQ-030 SHALL be a single module with no sub-module; the bench instantiates sync_fifo upstream to feed it.

Verification (W_IN=8, RATIO=4, sync_fifo upstream)
REQ-031 SHALL cover: push 0x11,0x22,0x33,0x44, out_ready=1 -> out_data 0x44332211, out_count 4, out_valid one cycle after 4th pop, single cycle.
REQ-032 SHALL cover: 8 words 0x11..0x88 queued, out_ready=0 -> first word held stable, fifo_ren low with cnt=3; raise out_ready -> 0x88776655 valid on the following cycle, no loss or duplication.
REQ-033 SHALL cover: push 0xAA,0xBB then flush_partial for one cycle -> out_data 0x0000BBAA, out_count 2, cnt returns to 0.
REQ-034 SHALL cover: flush_partial held with cnt=0 and FIFO non-empty -> no output from the flush, pops continue every cycle.
REQ-035 SHALL cover: cnt=2 then rst_n low one cycle -> out_valid 0, cnt 0; next 0x01..0x04 yield 0x04030201.
REQ-036 SHALL cover: 400 random words, random out_ready and flush_partial -> output lane stream equals input order, no fifo_ren while fifo_empty.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO: o_rdata shows the head entry whenever o_empty is low.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    output logic         o_full,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; entries are only readable after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow words popped from an upstream FWFT FIFO into one wide word; a flush request
// emits a partially filled word with zero upper lanes.
module stream_upsizer #(
    parameter int W_IN  = 8,
    parameter int RATIO = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W_IN-1:0]            fifo_rdata,
    input  logic                       fifo_empty,
    output logic                       fifo_ren,
    input  logic                       flush_partial,
    output logic [W_IN*RATIO-1:0]      out_data,
    output logic [$clog2(RATIO+1)-1:0] out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int W_OUT = W_IN * RATIO;
    localparam int W_CNT = $clog2(RATIO + 1);

    logic [RATIO-2:0][W_IN-1:0] r_acc;
    logic [W_CNT-1:0]           r_cnt;
    logic [W_OUT-1:0]           r_out_data;
    logic [W_CNT-1:0]           r_out_count;
    logic                       r_out_valid;

    logic                       w_out_free;
    logic                       w_flush_pend;
    logic                       w_last;
    logic [W_OUT-1:0]           w_flush_data;

    assign w_out_free   = !r_out_valid || out_ready;
    assign w_flush_pend = flush_partial && (r_cnt != '0);
    assign w_last       = (r_cnt == W_CNT'(RATIO - 1));

    // A pending flush owns the cycle, so the FIFO head waits for the next word.
    assign fifo_ren = rst_n && !fifo_empty && !w_flush_pend && (!w_last || w_out_free);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_flush_data = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (W_CNT'(i) < r_cnt) w_flush_data[i*W_IN +: W_IN] = r_acc[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
        end else if (w_flush_pend && w_out_free) begin
            r_out_data  <= w_flush_data;
            r_out_count <= r_cnt;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
        end else if (fifo_ren && w_last) begin
            r_out_data  <= {fifo_rdata, r_acc};
            r_out_count <= W_CNT'(RATIO);
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
        end else begin
            if (fifo_ren) begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (r_cnt == W_CNT'(i)) r_acc[i] <= fifo_rdata;
                end
                r_cnt <= r_cnt + W_CNT'(1);
            end
            if (out_ready) r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer fed by sync_fifo: directed corner cases, then a randomized stream
// checked against a queue of pushed lanes.
module tb_stream_upsizer;
    localparam int W_IN  = 8;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        full;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        fifo_ren;
    logic        flush_partial = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_q[$];

    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    logic [2:0]  hold_c = '0;

    always #5 clk = ~clk;

    sync_fifo #(.W(8), .DEPTH(16)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (push),
        .i_wdata (wdata),
        .o_full  (full),
        .i_pop   (fifo_ren),
        .o_rdata (fifo_rdata),
        .o_empty (fifo_empty)
    );

    stream_upsizer #(.W_IN(W_IN), .RATIO(RATIO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rdata    (fifo_rdata),
        .fifo_empty    (fifo_empty),
        .fifo_ren      (fifo_ren),
        .flush_partial (flush_partial),
        .out_data      (out_data),
        .out_count     (out_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        push  = 1'b1;
        wdata = d;
        cyc();
        push  = 1'b0;
    endtask

    // Stream monitor: each accepted word must carry the next out_count pushed lanes in order.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ren_while_empty", 64'(fifo_ren && fifo_empty), 0);
            if (hold_v && out_valid) begin
                check("hold_data", out_data, hold_d);
                check("hold_count", out_count, hold_c);
            end
            if (out_valid && out_ready) begin
                check("count_range", 64'(out_count >= 3'd1 && out_count <= 3'd4), 1);
                for (int l = 0; l < RATIO; l++) begin
                    if (l < int'(out_count)) begin
                        check("lane_avail", 64'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) check("lane_data", out_data[l*8 +: 8], exp_q.pop_front());
                    end else begin
                        check("lane_pad", out_data[l*8 +: 8], 0);
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_c = out_count;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int remaining;
        int guard;

        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", out_count, 0);
        check("rst_ren", fifo_ren, 0);
        check("rst_cnt", dut.r_cnt, 0);
        cyc();
        rst_n = 1'b1;

        // Four words, ready downstream: wide word one cycle after the fourth pop
        out_ready = 1'b1;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        @(negedge clk);
        check("t1_last_pop", fifo_ren, 1);
        check("t1_cnt3", dut.r_cnt, 3);
        check("t1_not_yet", out_valid, 0);
        cyc();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 32'h44332211);
        check("t1_count", out_count, 4);
        cyc();
        check("t1_single", out_valid, 0);

        // Backpressure: first word held, accumulator fills to three lanes and pops stop
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(8'(i * 17));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_ren_low", fifo_ren, 0);
            check("t2_cnt3", dut.r_cnt, 3);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_data", out_data, 32'h44332211);
            check("t2_hold_count", out_count, 4);
            check("t2_head_kept", fifo_empty, 0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_ren_resume", fifo_ren, 1);
        cyc();
        check("t2_valid2", out_valid, 1);
        check("t2_data2", out_data, 32'h88776655);
        check("t2_count2", out_count, 4);
        check("t2_fifo_drained", fifo_empty, 1);
        cyc();
        check("t2_no_dup", out_valid, 0);

        // Flush a two-lane partial word while the FIFO head waits, then a one-lane word
        push_word(8'hAA);
        push_word(8'hBB);
        push_word(8'hCC);
        flush_partial = 1'b1;
        @(negedge clk);
        check("t3_flush_prio", fifo_ren, 0);
        cyc();
        flush_partial = 1'b0;
        check("t3_valid", out_valid, 1);
        check("t3_data", out_data, 32'h0000BBAA);
        check("t3_count", out_count, 2);
        check("t3_cnt0", dut.r_cnt, 0);
        @(negedge clk);
        check("t3_head_pop", fifo_ren, 1);
        cyc();
        check("t3_drained", out_valid, 0);
        check("t3_cnt1", dut.r_cnt, 1);
        flush_partial = 1'b1;
        cyc();
        flush_partial = 1'b0;
        check("t3_one_data", out_data, 32'h000000CC);
        check("t3_one_count", out_count, 1);
        check("t3_one_valid", out_valid, 1);
        cyc();
        check("t3_one_gone", out_valid, 0);

        // Flush with an empty accumulator is ignored and does not block the pop
        push_word(8'h10);
        flush_partial = 1'b1;
        push  = 1'b1;
        wdata = 8'h20;
        @(negedge clk);
        check("t4_pop_during_flush", fifo_ren, 1);
        cyc();
        flush_partial = 1'b0;
        push = 1'b0;
        check("t4_no_output", out_valid, 0);
        check("t4_cnt1", dut.r_cnt, 1);
        push_word(8'h30);
        push_word(8'h40);
        cyc();
        check("t4_valid", out_valid, 1);
        check("t4_data", out_data, 32'h40302010);
        check("t4_count", out_count, 4);
        cyc();

        // Reset in the middle of a word discards the partial lanes
        push_word(8'h55);
        push_word(8'h66);
        push_word(8'h77);
        check("t5_cnt2", dut.r_cnt, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_head_present", fifo_empty, 0);
        check("t5_ren_in_reset", fifo_ren, 0);
        cyc();
        rst_n = 1'b1;
        check("t5_valid", out_valid, 0);
        check("t5_cnt0", dut.r_cnt, 0);
        check("t5_data", out_data, 0);
        check("t5_count", out_count, 0);
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        push_word(8'h04);
        cyc();
        check("t5_word_valid", out_valid, 1);
        check("t5_word_data", out_data, 32'h04030201);
        check("t5_word_count", out_count, 4);
        cyc();
        check("t5_word_gone", out_valid, 0);

        // Random stream with random backpressure and flushes
        mon_en = 1'b1;
        remaining = 400;
        while (remaining > 0) begin
            push  = !full && ($urandom_range(0, 3) != 0);
            wdata = 8'($urandom);
            if (push) begin
                exp_q.push_back(wdata);
                remaining--;
            end
            out_ready     = ($urandom_range(0, 2) != 0);
            flush_partial = ($urandom_range(0, 15) == 0);
            cyc();
        end
        push = 1'b0;
        out_ready = 1'b1;
        flush_partial = 1'b1;
        guard = 0;
        while ((exp_q.size() > 0 || out_valid) && guard < 2000) begin
            cyc();
            guard++;
        end
        flush_partial = 1'b0;
        mon_en = 1'b0;
        check("rand_drain_in_time", 64'(guard < 2000), 1);
        check("rand_lanes_left", exp_q.size(), 0);
        check("rand_fifo_empty", fifo_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
